div_unit: RTL and testbench

- Parametrised multi-cycle signed/unsigned integer divider for the MIPS32 execute stage; implements DIV/DIVU results written to HI/LO.
- Radix-2 restoring divider, one quotient bit per cycle.
- EX drives start/operands and holds `stallreq` while `busy_o` is high; the result returns as {remainder, quotient}, ready for HI/LO writeback.

---
 rtl/div_unit.sv | 154 +++++++++++++++
 tb/tb_div_unit.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : div_unit
//  Purpose  : Radix-2 restoring signed/unsigned divider for MIPS32 DIV/DIVU,
//             returning {remainder, quotient} for HI/LO writeback.
//  Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               signed_div_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    input  logic               start_i,
    input  logic               annul_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               busy_o
);

    localparam logic [1:0]       C_ST_IDLE   = 2'd0;
    localparam logic [1:0]       C_ST_BYZERO = 2'd1;
    localparam logic [1:0]       C_ST_ON     = 2'd2;
    localparam logic [1:0]       C_ST_END    = 2'd3;
    localparam logic [CNT_W-1:0] C_LAST_CNT  = CNT_W'(WIDTH - 1);

    logic [1:0]         r_state_q,  w_state_d;
    logic [CNT_W-1:0]   r_cnt_q,    w_cnt_d;
    logic [WIDTH:0]     r_rem_q,    w_rem_d;
    logic [WIDTH-1:0]   r_dvd_q,    w_dvd_d;
    logic [WIDTH-1:0]   r_dsr_q,    w_dsr_d;
    logic               r_sgn_q,    w_sgn_d;
    logic               r_neg1_q,   w_neg1_d;
    logic               r_neg2_q,   w_neg2_d;
    logic [2*WIDTH-1:0] r_result_q, w_result_d;
    logic               r_ready_q,  w_ready_d;

    logic [WIDTH-1:0]   w_mag1, w_mag2;
    logic [WIDTH:0]     w_shift, w_diff, w_rem_step;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_quo_step, w_quo_fix, w_rem_fix;

    // Magnitudes as WIDTH-bit unsigned: negating MIN wraps to 2^(WIDTH-1), which is exact.
    assign w_mag1 = (signed_div_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
    assign w_mag2 = (signed_div_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;

    // The dividend register doubles as the quotient: MSBs shift out, quotient bits shift in.
    assign w_shift    = {r_rem_q[WIDTH-1:0], r_dvd_q[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dsr_q};
    assign w_qbit     = ~w_diff[WIDTH];
    assign w_rem_step = w_qbit ? w_diff : w_shift;
    assign w_quo_step = {r_dvd_q[WIDTH-2:0], w_qbit};

    assign w_quo_fix = (r_sgn_q && (r_neg1_q ^ r_neg2_q)) ? -w_quo_step : w_quo_step;
    assign w_rem_fix = (r_sgn_q && r_neg1_q) ? -w_rem_step[WIDTH-1:0] : w_rem_step[WIDTH-1:0];

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_rem_d    = r_rem_q;
        w_dvd_d    = r_dvd_q;
        w_dsr_d    = r_dsr_q;
        w_sgn_d    = r_sgn_q;
        w_neg1_d   = r_neg1_q;
        w_neg2_d   = r_neg2_q;
        w_result_d = r_result_q;
        w_ready_d  = r_ready_q;
        case (r_state_q)
            C_ST_IDLE: begin
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        w_state_d = C_ST_BYZERO;
                    end else begin
                        w_state_d = C_ST_ON;
                        w_dvd_d   = w_mag1;
                        w_dsr_d   = w_mag2;
                        w_sgn_d   = signed_div_i;
                        w_neg1_d  = opdata1_i[WIDTH-1];
                        w_neg2_d  = opdata2_i[WIDTH-1];
                        w_cnt_d   = '0;
                        w_rem_d   = '0;
                    end
                end
            end
            C_ST_BYZERO: begin
                if (annul_i) begin
                    w_state_d = C_ST_IDLE;
                    w_ready_d = 1'b0;
                end else begin
                    w_state_d  = C_ST_END;
                    w_result_d = '0;
                    w_ready_d  = 1'b1;
                end
            end
            C_ST_ON: begin
                if (annul_i) begin
                    w_state_d = C_ST_IDLE;
                    w_ready_d = 1'b0;
                end else begin
                    w_rem_d = w_rem_step;
                    w_dvd_d = w_quo_step;
                    w_cnt_d = r_cnt_q + CNT_W'(1);
                    if (r_cnt_q == C_LAST_CNT) begin
                        w_state_d  = C_ST_END;
                        w_result_d = {w_rem_fix, w_quo_fix};
                        w_ready_d  = 1'b1;
                    end
                end
            end
            default: begin
                if (!start_i || annul_i) begin
                    w_state_d  = C_ST_IDLE;
                    w_ready_d  = 1'b0;
                    w_result_d = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= C_ST_IDLE;
            r_cnt_q    <= '0;
            r_rem_q    <= '0;
            r_dvd_q    <= '0;
            r_dsr_q    <= '0;
            r_sgn_q    <= 1'b0;
            r_neg1_q   <= 1'b0;
            r_neg2_q   <= 1'b0;
            r_result_q <= '0;
            r_ready_q  <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_rem_q    <= w_rem_d;
            r_dvd_q    <= w_dvd_d;
            r_dsr_q    <= w_dsr_d;
            r_sgn_q    <= w_sgn_d;
            r_neg1_q   <= w_neg1_d;
            r_neg2_q   <= w_neg2_d;
            r_result_q <= w_result_d;
            r_ready_q  <= w_ready_d;
        end
    end

    assign result_o = r_result_q;
    assign ready_o  = r_ready_q;
    assign busy_o   = (r_state_q == C_ST_BYZERO) || (r_state_q == C_ST_ON);

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_div_unit
//  Purpose  : Self-checking bench for div_unit (WIDTH=32 and WIDTH=8 instances)
//             against an arithmetic reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        sd, start, annul;
    logic [31:0] a, b;
    logic [63:0] result;
    logic        ready, busy;

    logic        sd8, start8, annul8;
    logic [7:0]  a8, b8;
    logic [15:0] res8;
    logic        rdy8, busy8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(32), .CNT_W(6)) u_dut32 (
        .clk(clk), .rst(rst), .signed_div_i(sd), .opdata1_i(a), .opdata2_i(b),
        .start_i(start), .annul_i(annul), .result_o(result), .ready_o(ready), .busy_o(busy)
    );

    div_unit #(.WIDTH(8), .CNT_W(4)) u_dut8 (
        .clk(clk), .rst(rst), .signed_div_i(sd8), .opdata1_i(a8), .opdata2_i(b8),
        .start_i(start8), .annul_i(annul8), .result_o(res8), .ready_o(rdy8), .busy_o(busy8)
    );

    // Reference: plain 64-bit integer division, truncating toward zero; {rem, quo} masked to w bits.
    function automatic logic [63:0] model(input bit s, input logic [31:0] x, input logic [31:0] y,
                                          input int w);
        longint tx, ty, q, r, m;
        if (y == 32'd0) return 64'd0;
        tx = {32'd0, x};
        ty = {32'd0, y};
        if (s) begin
            tx = (tx << (64 - w)) >>> (64 - w);
            ty = (ty << (64 - w)) >>> (64 - w);
        end
        q = tx / ty;
        r = tx % ty;
        m = (longint'(1) << w) - 1;
        return 64'(((r & m) << w) | (q & m));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered and left 1 time unit after a rising edge.
    task automatic op32(input bit s, input logic [31:0] x, input logic [31:0] y);
        int lat, nb;
        logic [63:0] e;
        e = model(s, x, y, 32);
        sd = s; a = x; b = y; start = 1'b1;
        lat = 0; nb = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (busy) nb++;
        end while (!ready && lat < 100);
        chk("lat32", 64'(lat), (y == 0) ? 64'd2 : 64'd33);
        chk("busy32", 64'(nb), (y == 0) ? 64'd1 : 64'd32);
        chk("res32", result, e);
        a = $urandom; b = $urandom; sd = ~s;
        @(posedge clk); #1;
        chk("hold32", {result[62:0], ready}, {e[62:0], 1'b1});
        start = 1'b0;
        @(posedge clk); #1;
        chk("clr32", {result, 1'b0}, {64'd0, ready});
    endtask

    task automatic op8(input bit s, input logic [7:0] x, input logic [7:0] y);
        int lat;
        logic [63:0] e;
        e = model(s, {24'd0, x}, {24'd0, y}, 8);
        sd8 = s; a8 = x; b8 = y; start8 = 1'b1;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!rdy8 && lat < 40);
        chk("lat8", 64'(lat), (y == 0) ? 64'd2 : 64'd9);
        chk("res8", {48'd0, res8}, {48'd0, e[15:0]});
        start8 = 1'b0;
        @(posedge clk); #1;
        chk("clr8", {47'd0, res8, rdy8}, 64'd0);
    endtask

    initial begin
        logic [31:0] rx, ry;
        bit          seen;
        rst = 1'b1; sd = 0; a = 0; b = 0; start = 0; annul = 0;
        sd8 = 0; a8 = 0; b8 = 0; start8 = 0; annul8 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_res", result, 64'd0);
        chk("rst_flags", {62'd0, ready, busy}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        op32(0, 32'd100, 32'd7);
        chk("tp_100_7", model(0, 32'd100, 32'd7, 32), 64'h00000002_0000000E);
        op32(1, 32'hFFFFFFF9, 32'd2);
        op32(1, 32'd7, 32'hFFFFFFFE);
        op32(0, 32'd5, 32'd0);
        op32(1, 32'h80000000, 32'hFFFFFFFF);
        op32(0, 32'hFFFFFFFF, 32'd1);
        op32(0, 32'h80000000, 32'hFFFFFFFF);

        // Annul at cycle 10 of an ON operation.
        sd = 0; a = 32'd100; b = 32'd7; start = 1'b1;
        repeat (9) @(posedge clk);
        #1; annul = 1'b1;
        @(posedge clk); #1;
        chk("annul_idle", {62'd0, ready, busy}, 64'd0);
        annul = 1'b0; start = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (ready) seen = 1;
        end
        chk("annul_norise", {63'd0, seen}, 64'd0);
        op32(0, 32'd9, 32'd3);

        // Reset in the middle of an operation.
        sd = 1; a = 32'd1000; b = 32'hFFFFFFFD; start = 1'b1;
        repeat (6) @(posedge clk);
        #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst", {result, ready, busy}, 66'd0);
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) begin
            rx = $urandom;
            case ($urandom_range(0, 4))
                0: ry = $urandom;
                1: ry = $urandom_range(1, 20);
                2: ry = -$urandom_range(1, 20);
                3: ry = 32'd0;
                default: ry = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 5) == 0) rx = 32'h80000000;
            op32($urandom_range(0, 1) == 1, rx, ry);
        end

        op8(1, 8'h80, 8'h03);
        op8(1, 8'h80, 8'hFF);
        op8(0, 8'hFF, 8'h03);
        op8(1, 8'd50, 8'd0);
        for (int i = 0; i < 8; i++) begin
            rx = $urandom;
            ry = $urandom_range(1, 255);
            op8($urandom_range(0, 1) == 1, rx[7:0], ry[7:0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
